pipe_lock_ctrl: RTL and testbench
=================================

// Module: pipe_lock_ctrl
// PURPOSE
//   Pipeline lock controller. Generates the per-stage lock (buffer disable) and
//   flush (bubble) controls that drive the lockBuffer pipeline registers.
//   Turns hazard, memory-wait and branch events into cycle-exact hold/squash
//   sequences. Sits in the CPU control path beside the decoder.
// PARAMETERS
//   HAZ_CYCLES   1   load-use stall length in cycles; 0 is treated as 1
//   MEM_TIMEOUT  15  memory-stall cycle count at which mem_timeout is raised
//   CNT_W        4   stall counter width; must hold max(HAZ_CYCLES,MEM_TIMEOUT)
// PORTS
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   haz_req      in   1  load-use hazard detected in ID (level)
//   mem_busy     in   1  data memory not ready (level)
//   br_taken     in   1  branch resolved taken in EX (level)
//   lock         out  4  1 = hold buffer: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM
//   flush        out  4  1 = load bubble (zero) into buffer, same index map as lock
//   state        out  2  current FSM state, for debug
//   mem_timeout  out  1  sticky; memory stall reached MEM_TIMEOUT
// BEHAVIOUR
//   - Clock and reset: one clock domain. Reset is asynchronous, active-low.
//   - Registered Moore outputs: lock, flush and state are decoded from the
//     state register. Response is 1 cycle after the request edge.
//   - Requesters hold their input level until it is serviced.
//   - Reset (async, any time, including mid-stall):
//     state=RUN, lock=0000, flush=0000, cnt=0, mem_timeout=0.
//   - Entry priority from RUN: mem_busy > br_taken > haz_req.
//   - States, with outputs and transitions:
//     RUN   (00): lock=0000 flush=0000.
//                 mem_busy -> MEM (cnt=0).
//                 Else br_taken -> FLUSH.
//                 Else haz_req -> HAZ (cnt=HAZ_CYCLES-1).
//                 Else stay in RUN.
//     HAZ   (01): lock=0011 flush=0100.
//                 mem_busy -> MEM.
//                 Else br_taken -> FLUSH (branch squashes the dependent instruction).
//                 Else cnt==0 -> RUN.
//                 Else cnt-1.
//     MEM   (10): lock=1111 flush=0000.
//                 cnt increments each cycle, saturating at all-ones.
//                 When cnt==MEM_TIMEOUT-1 and mem_busy is still 1,
//                 mem_timeout <= 1 (sticky until reset).
//                 Exit on mem_busy==0: to FLUSH if br_taken, else to RUN.
//     FLUSH (11): exactly 1 cycle. lock=0000 flush=0110.
//                 mem_busy -> MEM, else -> RUN.
//                 haz_req is ignored in FLUSH (ID is being squashed).
//   - lock and flush are never both 1 on the same bit.
//   - Simultaneous events resolve strictly by the priority above. No request is
//     queued except a branch pending across MEM.
// CONFIGURATION
//   PIPE_STALL_CNT_EN defined:
//     adds output stall_cycles [31:0]. It counts cycles spent in HAZ or MEM,
//     wraps at 2^32, and resets to 0.
//   PIPE_STALL_CNT_EN undefined:
//     the port and the counter do not exist. All other behaviour is identical.
// STRUCTURE
//   pipe_ctrl_pkg: state encodings (RUN/HAZ/MEM/FLUSH), stage index constants
//     (STG_PC=0, STG_IFID=1, STG_IDEX=2, STG_EXMEM=3), lock/flush pattern
//     constants per state.
//   Sub-module lock_timer: CNT_W-bit loadable counter with inputs load,
//     load_val, up/down; outputs zero and sat flags. It serves both HAZ and MEM.
//   FSM and output decode stay in pipe_lock_ctrl.
// TESTING
//   1 rst_n=0 at the 3rd cycle of MEM -> immediately lock=0000, state=00,
//     mem_timeout=0, with no clock edge needed.
//   2 haz_req=1 for 1 cycle (HAZ_CYCLES=1) -> next edge lock=0011 flush=0100
//     for exactly 1 cycle, then lock=0000 flush=0000.
//   3 mem_busy=1 for 3 cycles -> lock=1111 for 3 cycles, mem_timeout=0.
//     mem_busy=1 for 20 cycles -> mem_timeout=1 after the 15th MEM cycle,
//     still 1 after mem_busy drops.
//   4 haz_req=1 and br_taken=1 together from RUN -> one cycle lock=0000
//     flush=0110 (FLUSH), HAZ never entered.
//   5 mem_busy=1 and br_taken=1 together -> MEM (lock=1111) while busy. On
//     mem_busy=0 with br_taken still 1 -> FLUSH for 1 cycle, then RUN.
//   6 PIPE_STALL_CNT_EN build, scenario 2 then the 3-cycle part of scenario 3
//     -> stall_cycles=4. Non-_EN build compiles without the port.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline lock controller: state encoding,
// stage bit positions and per-state lock/flush patterns.
package pipe_ctrl_pkg;

  localparam int NUM_STG   = 4;
  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HAZ   = 2'b01,
    ST_MEM   = 2'b10,
    ST_FLUSH = 2'b11
  } pipe_st_t;

  typedef struct packed {
    logic [NUM_STG-1:0] lock;
    logic [NUM_STG-1:0] flush;
  } stg_ctrl_t;

  // HAZ holds PC and IF/ID and bubbles ID/EX; FLUSH squashes IF/ID and ID/EX.
  localparam logic [NUM_STG-1:0] LOCK_HAZ  = (1 << STG_PC) | (1 << STG_IFID);
  localparam logic [NUM_STG-1:0] FLUSH_HAZ = (1 << STG_IDEX);
  localparam logic [NUM_STG-1:0] LOCK_MEM  = (1 << STG_PC) | (1 << STG_IFID) |
                                             (1 << STG_IDEX) | (1 << STG_EXMEM);
  localparam logic [NUM_STG-1:0] FLUSH_BR  = (1 << STG_IFID) | (1 << STG_IDEX);

  function automatic stg_ctrl_t ctrl_of(input pipe_st_t st);
    stg_ctrl_t c;
    c = '0;
    case (st)
      ST_HAZ:   begin c.lock = LOCK_HAZ; c.flush = FLUSH_HAZ; end
      ST_MEM:   c.lock  = LOCK_MEM;
      ST_FLUSH: c.flush = FLUSH_BR;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable up/down stall counter shared by the HAZ countdown and MEM count-up.
// Counting saturates at zero going down and at all-ones going up.
module lock_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
  assign sat  = (cnt_q == '1);

  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = load_val;
    else if (en && up && !sat)    cnt_d = cnt_q + 1'b1;
    else if (en && !up && !zero)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pipe_lock_ctrl.sv
// Pipeline lock controller: turns hazard, memory-wait and branch events into
// per-stage lock/flush sequences. Optional stall counter under PIPE_STALL_CNT_EN.
module pipe_lock_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int HAZ_CYCLES  = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               haz_req,
  input  logic               mem_busy,
  input  logic               br_taken,
  output logic [NUM_STG-1:0] lock,
  output logic [NUM_STG-1:0] flush,
  output logic [1:0]         state,
  output logic               mem_timeout
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  localparam int HAZ_EFF = (HAZ_CYCLES < 1) ? 1 : HAZ_CYCLES;
  localparam logic [CNT_W-1:0] HAZ_LOAD = CNT_W'(HAZ_EFF - 1);
  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_TIMEOUT - 1);

  pipe_st_t         state_q, state_d;
  stg_ctrl_t        ctrl_q;
  logic             to_q, to_d;
  logic             t_load, t_en, t_up, t_zero, t_sat;
  logic [CNT_W-1:0] t_val, t_cnt;

  lock_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .up       (t_up),
    .cnt      (t_cnt),
    .zero     (t_zero),
    .sat      (t_sat)
  );

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_en    = 1'b0;
    t_up    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_busy)      state_d = ST_MEM;
        else if (br_taken) state_d = ST_FLUSH;
        else if (haz_req) begin
          state_d = ST_HAZ;
          t_load  = 1'b1;
          t_val   = HAZ_LOAD;
        end
      end
      ST_HAZ: begin
        if (mem_busy)      state_d = ST_MEM;
        else if (br_taken) state_d = ST_FLUSH;
        else if (t_zero)   state_d = ST_RUN;
        else               t_en    = 1'b1;
      end
      ST_MEM: begin
        t_en = 1'b1;
        t_up = 1'b1;
        if (mem_busy && t_cnt == MEM_LAST) to_d = 1'b1;
        // A branch resolved during the stall is the one request kept pending.
        if (!mem_busy) state_d = br_taken ? ST_FLUSH : ST_RUN;
      end
      ST_FLUSH: state_d = mem_busy ? ST_MEM : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (state_d == ST_MEM && state_q != ST_MEM) begin
      t_load = 1'b1;
      t_val  = '0;
    end
  end

  // Outputs are registered from the next state so they change with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      ctrl_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
      to_q    <= to_d;
    end
  end

  assign lock        = ctrl_q.lock;
  assign flush       = ctrl_q.flush;
  assign state       = state_q;
  assign mem_timeout = to_q;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else if (state_q == ST_HAZ || state_q == ST_MEM) stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_lock_ctrl.sv
// Self-checking bench for pipe_lock_ctrl: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_pipe_lock_ctrl;

  localparam int HAZ_CYCLES  = 1;
  localparam int MEM_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       haz_req, mem_busy, br_taken;
  logic [3:0] lock, flush;
  logic [1:0] state;
  logic       mem_timeout;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // model
  logic [1:0] m_st;
  logic       m_to;
  int         m_hleft, m_memn;
  int unsigned m_stall;

  always #5 clk = ~clk;

  pipe_lock_ctrl #(.HAZ_CYCLES(HAZ_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .haz_req     (haz_req),
    .mem_busy    (mem_busy),
    .br_taken    (br_taken),
    .lock        (lock),
    .flush       (flush),
    .state       (state),
    .mem_timeout (mem_timeout)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  function automatic logic [3:0] exp_lock(input logic [1:0] s);
    case (s)
      2'd1:    return 4'b0011;
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] exp_flush(input logic [1:0] s);
    case (s)
      2'd1:    return 4'b0100;
      2'd3:    return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  `define CHK(NM) \
    n_cmp++; \
    if (state !== m_st || lock !== exp_lock(m_st) || flush !== exp_flush(m_st) || mem_timeout !== m_to) begin \
      n_fail++; \
      $display("FAIL %s t=%0t: st=%0d lock=%b flush=%b to=%b, want st=%0d lock=%b flush=%b to=%b", \
               NM, $time, state, lock, flush, mem_timeout, m_st, exp_lock(m_st), exp_flush(m_st), m_to); \
    end

  task automatic model_reset();
    m_st = 2'd0; m_to = 1'b0; m_hleft = 0; m_memn = 0; m_stall = 0;
  endtask

  // RUN=0 HAZ=1 MEM=2 FLUSH=3; m_memn = number of MEM cycles already completed.
  task automatic model_step(input logic h, input logic m, input logic b);
    if (m_st == 2'd1 || m_st == 2'd2) m_stall++;
    case (m_st)
      2'd0, 2'd1: begin
        if (m) begin m_st = 2'd2; m_memn = 0; end
        else if (b) m_st = 2'd3;
        else if (m_st == 2'd0) begin
          if (h) begin m_st = 2'd1; m_hleft = (HAZ_CYCLES < 1 ? 1 : HAZ_CYCLES) - 1; end
        end
        else if (m_hleft == 0) m_st = 2'd0;
        else m_hleft--;
      end
      2'd2: begin
        if (m && m_memn + 1 >= MEM_TIMEOUT) m_to = 1'b1;
        m_memn++;
        if (!m) m_st = b ? 2'd3 : 2'd0;
      end
      default: begin
        if (m) begin m_st = 2'd2; m_memn = 0; end
        else m_st = 2'd0;
      end
    endcase
  endtask

  task automatic tick(input logic h, input logic m, input logic b);
    @(negedge clk);
    haz_req = h; mem_busy = m; br_taken = b;
    @(posedge clk);
    model_step(h, m, b);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; haz_req = 0; mem_busy = 0; br_taken = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; haz_req = 0; mem_busy = 0; br_taken = 0;
    model_reset();
    #12;
    `CHK("reset")
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0, 0);
    `CHK("reset_idle")
  endtask

  task automatic test_haz();
    do_reset();
    tick(1, 0, 0);
    `CHK("haz_enter")
    n_cmp++;
    if (lock !== 4'b0011 || flush !== 4'b0100) begin
      n_fail++; $display("FAIL haz_pattern: lock=%b flush=%b want 0011/0100", lock, flush);
    end
    tick(0, 0, 0);
    `CHK("haz_exit")
    tick(0, 0, 0);
    `CHK("haz_idle")
  endtask

  task automatic test_mem_short();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0);
      `CHK("mem3_busy")
    end
    tick(0, 0, 0);
    `CHK("mem3_exit")
    n_cmp++;
    if (mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL mem3_timeout: got %b want 0", mem_timeout);
    end
  endtask

  task automatic test_mem_timeout();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 0);
      `CHK("mem20_busy")
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0);
      `CHK("mem20_after")
    end
    n_cmp++;
    if (mem_timeout !== 1'b1) begin
      n_fail++; $display("FAIL mem20_sticky: got %b want 1", mem_timeout);
    end
    // 15 busy edges stay under the limit, 16 reach it
    do_reset();
    for (int i = 0; i < 15; i++) tick(0, 1, 0);
    tick(0, 0, 0);
    `CHK("mem15_edge")
    do_reset();
    for (int i = 0; i < 16; i++) tick(0, 1, 0);
    tick(0, 0, 0);
    `CHK("mem16_edge")
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 20; i++) tick(0, 1, 0);
    do_reset();
    for (int i = 0; i < 3; i++) tick(0, 1, 0);
    `CHK("mem_before_rst")
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    `CHK("async_rst")
    @(negedge clk);
    mem_busy = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_haz_br();
    do_reset();
    tick(1, 0, 1);
    `CHK("hazbr_flush")
    tick(0, 0, 0);
    `CHK("hazbr_run")
    n_cmp++;
    if (state !== 2'b00) begin
      n_fail++; $display("FAIL hazbr_state: got %0d want 0", state);
    end
  endtask

  task automatic test_mem_br();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 1);
      `CHK("membr_busy")
    end
    tick(0, 0, 1);
    `CHK("membr_flush")
    tick(0, 0, 0);
    `CHK("membr_run")
  endtask

  task automatic test_stall_cnt();
`ifdef PIPE_STALL_CNT_EN
    do_reset();
    tick(1, 0, 0);
    tick(0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 0);
    tick(0, 0, 0);
    n_cmp++;
    if (stall_cycles !== 32'd4) begin
      n_fail++; $display("FAIL stall_cnt: got %0d want 4", stall_cycles);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      `CHK("random")
`ifdef PIPE_STALL_CNT_EN
      n_cmp++;
      if (stall_cycles !== m_stall) begin
        n_fail++; $display("FAIL random_stall: got %0d want %0d", stall_cycles, m_stall);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_haz();
    test_mem_short();
    test_mem_timeout();
    test_async_reset();
    test_haz_br();
    test_mem_br();
    test_stall_cnt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
